bc_turn_scheduler: RTL and testbench

- Turn controller for the two-player Bulls & Cows game on the Nexys A7.
- Latches both players' secrets and alternates guess turns P1/P2. Validates each guess, then sequences the digit-scoring datapath one digit per cycle.
- Reports bulls/cows and declares win or draw. Sits between the switch/confirm front end and the display/LED driver.

---
 rtl/bc_pkg.sv | 35 +++
 rtl/bc_turn_scheduler_digit_match.sv | 26 ++
 rtl/bc_turn_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_bc_turn_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types and helpers for the Bulls & Cows turn controller and its setup logic.
package bc_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned CODE_W     = NUM_DIGITS * DIGIT_W;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_GUESS = 3'd1,
    CHECK      = 3'd2,
    SCORE      = 3'd3,
    REPORT     = 3'd4,
    WIN        = 3'd5,
    DRAW       = 3'd6
  } state_t;

  // A code is legal when every nibble is a decimal digit and no digit repeats.
  function automatic logic digits_distinct_valid(input logic [CODE_W-1:0] code);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (code[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) ok = 1'b0;
      for (int unsigned j = i + 1; j < NUM_DIGITS; j++) begin
        if (code[i*DIGIT_W +: DIGIT_W] == code[j*DIGIT_W +: DIGIT_W]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bc_turn_scheduler_digit_match.sv
// Scores one guess digit against a full secret: bull on same position, cow elsewhere.
module bc_digit_match
  import bc_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic [IDX_W-1:0]   pos_i,
  input  logic [CODE_W-1:0]  secret_i,
  output logic               bull_o,
  output logic               cow_o
);

  logic other_hit;

  always_comb begin
    bull_o    = 1'b0;
    other_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (secret_i[i*DIGIT_W +: DIGIT_W] == digit_i) begin
        if (IDX_W'(i) == pos_i) bull_o = 1'b1;
        else                    other_hit = 1'b1;
      end
    end
    cow_o = other_hit & ~bull_o;
  end

endmodule

// File: rtl/bc_turn_scheduler.sv
// Two-player Bulls & Cows turn controller: latches secrets, alternates guesses, scores, declares win/draw.
// Build option BC_PARALLEL_SCORE_EN scores all digits in a single SCORE cycle.
module bc_turn_scheduler
  import bc_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              new_game,
  input  logic              secrets_valid,
  input  logic [CODE_W-1:0] p1_secret,
  input  logic [CODE_W-1:0] p2_secret,
  input  logic              guess_stb,
  input  logic [CODE_W-1:0] guess,
  output logic              cur_player,
  output logic              busy,
  output logic              reject,
  output logic              result_valid,
  output logic [2:0]        bulls,
  output logic [2:0]        cows,
  output logic              win,
  output logic              winner,
  output logic              draw,
  output logic [3:0]        round_cnt,
  output logic [2:0]        state_code
);

  state_t            state_q;
  logic [CODE_W-1:0] p1_q, p2_q, guess_q;
  logic              cur_player_q, reject_q, result_valid_q;
  logic              win_q, winner_q, draw_q;
  logic [2:0]        bulls_q, cows_q;
  logic [3:0]        round_cnt_q;
  logic [2:0]        bulls_d, cows_d;
  logic [CODE_W-1:0] opp_secret;

  assign opp_secret = (cur_player_q == P1) ? p2_q : p1_q;

`ifdef BC_PARALLEL_SCORE_EN
  logic [NUM_DIGITS-1:0] bull_v, cow_v;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_match
    bc_digit_match u_match (
      .digit_i  (guess_q[g*DIGIT_W +: DIGIT_W]),
      .pos_i    (IDX_W'(g)),
      .secret_i (opp_secret),
      .bull_o   (bull_v[g]),
      .cow_o    (cow_v[g])
    );
  end

  always_comb begin
    bulls_d = '0;
    cows_d  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      bulls_d = bulls_d + 3'(bull_v[i]);
      cows_d  = cows_d + 3'(cow_v[i]);
    end
  end
`else
  logic [IDX_W-1:0] idx_q;
  logic             bull_s, cow_s;

  bc_digit_match u_match (
    .digit_i  (guess_q[idx_q*DIGIT_W +: DIGIT_W]),
    .pos_i    (idx_q),
    .secret_i (opp_secret),
    .bull_o   (bull_s),
    .cow_o    (cow_s)
  );

  assign bulls_d = bulls_q + 3'(bull_s);
  assign cows_d  = cows_q + 3'(cow_s);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      p1_q           <= '0;
      p2_q           <= '0;
      guess_q        <= '0;
      cur_player_q   <= P1;
      reject_q       <= 1'b0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      winner_q       <= 1'b0;
      draw_q         <= 1'b0;
      bulls_q        <= '0;
      cows_q         <= '0;
      round_cnt_q    <= '0;
`ifndef BC_PARALLEL_SCORE_EN
      idx_q          <= '0;
`endif
    end else if (new_game) begin
      state_q        <= IDLE;
      p1_q           <= '0;
      p2_q           <= '0;
      guess_q        <= '0;
      cur_player_q   <= P1;
      reject_q       <= 1'b0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      winner_q       <= 1'b0;
      draw_q         <= 1'b0;
      bulls_q        <= '0;
      cows_q         <= '0;
      round_cnt_q    <= '0;
`ifndef BC_PARALLEL_SCORE_EN
      idx_q          <= '0;
`endif
    end else begin
      reject_q       <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (secrets_valid) begin
            p1_q         <= p1_secret;
            p2_q         <= p2_secret;
            cur_player_q <= P1;
            round_cnt_q  <= '0;
            state_q      <= WAIT_GUESS;
          end
        end
        WAIT_GUESS: begin
          if (guess_stb) begin
            guess_q <= guess;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!digits_distinct_valid(guess_q)) begin
            reject_q <= 1'b1;
            state_q  <= WAIT_GUESS;
          end else begin
            bulls_q <= '0;
            cows_q  <= '0;
`ifndef BC_PARALLEL_SCORE_EN
            idx_q   <= '0;
`endif
            state_q <= SCORE;
          end
        end
        SCORE: begin
          bulls_q <= bulls_d;
          cows_q  <= cows_d;
`ifdef BC_PARALLEL_SCORE_EN
          result_valid_q <= 1'b1;
          state_q        <= REPORT;
`else
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            result_valid_q <= 1'b1;
            state_q        <= REPORT;
          end
`endif
        end
        REPORT: begin
          if (bulls_q == 3'(NUM_DIGITS)) begin
            win_q    <= 1'b1;
            winner_q <= cur_player_q;
            state_q  <= WIN;
          end else if (cur_player_q == P2 && (round_cnt_q + 4'd1) == 4'(MAX_ROUNDS)) begin
            round_cnt_q <= round_cnt_q + 4'd1;
            draw_q      <= 1'b1;
            state_q     <= DRAW;
          end else begin
            if (cur_player_q == P2) round_cnt_q <= round_cnt_q + 4'd1;
            cur_player_q <= ~cur_player_q;
            state_q      <= WAIT_GUESS;
          end
        end
        WIN, DRAW: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cur_player   = cur_player_q;
  assign busy         = (state_q == CHECK) || (state_q == SCORE) || (state_q == REPORT);
  assign reject       = reject_q;
  assign result_valid = result_valid_q;
  assign bulls        = bulls_q;
  assign cows         = cows_q;
  assign win          = win_q;
  assign winner       = winner_q;
  assign draw         = draw_q;
  assign round_cnt    = round_cnt_q;
  assign state_code   = state_q;

endmodule

// File: tb/tb_bc_turn_scheduler.sv
// Self-checking bench for bc_turn_scheduler: directed table, corner sequences, randomized games vs a game-level model.
module tb_bc_turn_scheduler;

  localparam int unsigned MAXR = 2;
`ifdef BC_PARALLEL_SCORE_EN
  localparam int RV_CYC = 3;
`else
  localparam int RV_CYC = 6;
`endif
  localparam int S_IDLE = 0, S_WAIT = 1, S_CHECK = 2, S_WIN = 5, S_DRAW = 6;

  logic        clock, reset, new_game, secrets_valid, guess_stb;
  logic [15:0] p1_secret, p2_secret, guess;
  logic        cur_player, busy, reject, result_valid, win, winner, draw;
  logic [2:0]  bulls, cows, state_code;
  logic [3:0]  round_cnt;

  bc_turn_scheduler #(.MAX_ROUNDS(MAXR)) dut (
    .clock(clock), .reset(reset), .new_game(new_game), .secrets_valid(secrets_valid),
    .p1_secret(p1_secret), .p2_secret(p2_secret), .guess_stb(guess_stb), .guess(guess),
    .cur_player(cur_player), .busy(busy), .reject(reject), .result_valid(result_valid),
    .bulls(bulls), .cows(cows), .win(win), .winner(winner), .draw(draw),
    .round_cnt(round_cnt), .state_code(state_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // game-level model
  int          m_phase, m_cur, m_rounds, m_win, m_winner, m_draw, m_bulls, m_cows;
  logic [15:0] m_s1, m_s2;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  function automatic bit model_valid(input logic [15:0] g);
    bit seen [16];
    bit ok = 1'b1;
    logic [3:0] d;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = g[i*4 +: 4];
      if (d > 4'd9 || seen[d]) ok = 1'b0;
      seen[d] = 1'b1;
    end
    return ok;
  endfunction

  function automatic void model_score(input logic [15:0] g, input logic [15:0] s, output int b, output int c);
    b = 0;
    c = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (g[i*4 +: 4] == s[j*4 +: 4]) begin
          if (i == j) b++;
          else        c++;
        end
  endfunction

  function automatic logic [15:0] rand_code();
    int unsigned pool [10];
    int unsigned k, tmp;
    logic [15:0] r = '0;
    for (int i = 0; i < 10; i++) pool[i] = i;
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(9, i);
      tmp = pool[i]; pool[i] = pool[k]; pool[k] = tmp;
      r[i*4 +: 4] = 4'(pool[i]);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_phase = S_IDLE; m_cur = 0; m_rounds = 0; m_win = 0; m_winner = 0; m_draw = 0;
    m_bulls = 0; m_cows = 0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_report(input int b, input int c);
    m_bulls = b;
    m_cows  = c;
    if (b == 4) begin
      m_win = 1; m_winner = m_cur; m_phase = S_WIN;
    end else if (m_cur == 1 && m_rounds + 1 == MAXR) begin
      m_rounds++; m_draw = 1; m_phase = S_DRAW;
    end else begin
      if (m_cur == 1) m_rounds++;
      m_cur = 1 - m_cur;
      m_phase = S_WAIT;
    end
  endtask

  task automatic check_all(input string n);
    chk({n, " state_code"}, state_code, m_phase);
    chk({n, " cur_player"}, cur_player, m_cur);
    chk({n, " round_cnt"}, round_cnt, m_rounds);
    chk({n, " win"}, win, m_win);
    chk({n, " winner"}, winner, m_winner);
    chk({n, " draw"}, draw, m_draw);
    chk({n, " bulls"}, bulls, m_bulls);
    chk({n, " cows"}, cows, m_cows);
    chk({n, " busy"}, busy, 0);
    chk({n, " reject"}, reject, 0);
    chk({n, " result_valid"}, result_valid, 0);
  endtask

  task automatic do_new_game(input string n);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_reset();
    check_all({n, " new_game"});
  endtask

  task automatic do_secrets(input string n, input logic [15:0] s1, input logic [15:0] s2);
    p1_secret = s1;
    p2_secret = s2;
    secrets_valid = 1'b1;
    tick();
    secrets_valid = 1'b0;
    if (m_phase == S_IDLE) begin
      m_s1 = s1; m_s2 = s2; m_cur = 0; m_rounds = 0; m_phase = S_WAIT;
    end
    check_all({n, " secrets"});
  endtask

  // One guess strobe; expected validity/score from the table when use_tbl, else from the model.
  task automatic do_guess(input string n, input logic [15:0] g, input bit use_tbl,
                          input bit t_valid, input int t_b, input int t_c);
    bit accept, v, exp_busy;
    int b, c, rv_at, rv_n, rj_at, rj_n, bsy_err, cap_b, cap_c;
    accept = (m_phase == S_WAIT);
    if (use_tbl) begin
      v = t_valid; b = t_b; c = t_c;
    end else begin
      v = model_valid(g);
      model_score(g, (m_cur == 1) ? m_s1 : m_s2, b, c);
    end
    rv_at = 0; rv_n = 0; rj_at = 0; rj_n = 0; bsy_err = 0; cap_b = 0; cap_c = 0;
    guess = g;
    guess_stb = 1'b1;
    tick();
    guess_stb = 1'b0;
    for (int cyc = 1; cyc <= RV_CYC; cyc++) begin
      exp_busy = accept && (v || cyc == 1);
      if (cyc == 1) chk({n, " state@1"}, state_code, accept ? S_CHECK : m_phase);
      if (busy !== exp_busy) bsy_err++;
      if (result_valid === 1'b1) begin
        rv_n++;
        if (rv_at == 0) rv_at = cyc;
        cap_b = int'(bulls);
        cap_c = int'(cows);
      end
      if (reject === 1'b1) begin
        rj_n++;
        if (rj_at == 0) rj_at = cyc;
      end
      guess_stb = exp_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      guess = 16'($urandom);
      tick();
    end
    guess_stb = 1'b0;
    chk({n, " result_valid count"}, rv_n, (accept && v) ? 1 : 0);
    chk({n, " result_valid cycle"}, rv_at, (accept && v) ? RV_CYC : 0);
    chk({n, " reject count"}, rj_n, (accept && !v) ? 1 : 0);
    chk({n, " reject cycle"}, rj_at, (accept && !v) ? 2 : 0);
    chk({n, " busy profile errors"}, bsy_err, 0);
    if (accept && v) begin
      chk({n, " bulls@rv"}, cap_b, b);
      chk({n, " cows@rv"}, cap_c, c);
      model_report(b, c);
    end
    check_all({n, " after"});
  endtask

  typedef struct {
    bit          restart;
    logic [15:0] s1, s2, g;
    bit          valid;
    int          b, c;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [15:0] g;
    int sel;

    reset = 1'b1; new_game = 1'b0; secrets_valid = 1'b0; guess_stb = 1'b0;
    p1_secret = '0; p2_secret = '0; guess = '0;
    model_reset();
    #2 reset = 1'b0;
    tick(); tick();
    check_all("reset");
    reset = 1'b1;
    tick();
    check_all("post_reset");

    tbl[0] = '{1'b1, 16'h9012, 16'h1234, 16'h1123, 1'b0, 0, 0};
    tbl[1] = '{1'b0, 16'h9012, 16'h1234, 16'h12A4, 1'b0, 0, 0};
    tbl[2] = '{1'b0, 16'h9012, 16'h1234, 16'h4321, 1'b1, 0, 4};
    tbl[3] = '{1'b0, 16'h9012, 16'h1234, 16'h5678, 1'b1, 0, 0};
    tbl[4] = '{1'b0, 16'h9012, 16'h1234, 16'h1243, 1'b1, 2, 2};
    tbl[5] = '{1'b0, 16'h9012, 16'h1234, 16'h9021, 1'b1, 2, 2};
    tbl[6] = '{1'b0, 16'h9012, 16'h1234, 16'h1234, 1'b1, 4, 0};
    tbl[7] = '{1'b1, 16'h9012, 16'h1234, 16'h5678, 1'b1, 0, 0};
    tbl[8] = '{1'b0, 16'h9012, 16'h1234, 16'h9012, 1'b1, 4, 0};
    tbl[9] = '{1'b1, 16'h9012, 16'h1234, 16'h1234, 1'b1, 4, 0};

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].restart) begin
        do_new_game($sformatf("tbl%0d", i));
        do_secrets($sformatf("tbl%0d", i), tbl[i].s1, tbl[i].s2);
      end
      do_guess($sformatf("tbl%0d", i), tbl[i].g, 1'b1, tbl[i].valid, tbl[i].b, tbl[i].c);
    end

    // new_game out of WIN
    do_new_game("win_exit");

    // reset in the middle of scoring, then guesses need fresh secrets
    do_secrets("mid_rst", 16'h3579, 16'h2468);
    guess = 16'h8642;
    guess_stb = 1'b1;
    tick();
    guess_stb = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst asserted");
    reset = 1'b1;
    tick();
    check_all("mid_rst released");
    do_guess("idle_guess", 16'h2468, 1'b0, 1'b0, 0, 0);
    do_secrets("mid_rst2", 16'h3579, 16'h2468);
    do_guess("mid_rst2", 16'h2468, 1'b0, 1'b0, 0, 0);

    // new_game wins over a simultaneous guess strobe
    do_new_game("prio_setup");
    do_secrets("prio", 16'h0123, 16'h4567);
    guess = 16'h4567;
    guess_stb = 1'b1;
    new_game = 1'b1;
    tick();
    guess_stb = 1'b0;
    new_game = 1'b0;
    model_reset();
    check_all("prio new_game");

    for (int gm = 0; gm < 12; gm++) begin
      do_new_game($sformatf("rnd%0d", gm));
      do_secrets($sformatf("rnd%0d", gm), rand_code(), rand_code());
      for (int t = 0; t < 7; t++) begin
        sel = $urandom_range(0, 9);
        if (sel < 2)      g = 16'($urandom);
        else if (sel < 4) g = (m_cur == 1) ? m_s1 : m_s2;
        else              g = rand_code();
        do_guess($sformatf("rnd%0d.%0d", gm, t), g, 1'b0, 1'b0, 0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
